// File: rtl/regfile_writeback_if.sv
// Register-file write-back bus: ALU results, load issue and response streams in,
// the single register-file write port and scoreboard status out.
interface regfile_writeback_if #(
  parameter int W     = 31,
  parameter int LQ_AW = 2
);
  logic         alu_valid;
  logic         alu_ready;
  logic [4:0]   alu_rd;
  logic [W:0]   alu_data;
  logic         ld_issue_valid;
  logic         ld_issue_ready;
  logic [4:0]   ld_issue_rd;
  logic         ld_resp_valid;
  logic [W:0]   ld_resp_data;
  logic         wen;
  logic [4:0]   wadd;
  logic [W:0]   wdata;
  logic [31:0]  busy;
  logic [LQ_AW:0] lq_count;
  logic         err;

  modport master (
    output alu_valid, alu_rd, alu_data,
    output ld_issue_valid, ld_issue_rd,
    output ld_resp_valid, ld_resp_data,
    input  alu_ready, ld_issue_ready,
    input  wen, wadd, wdata, busy, lq_count, err
  );

  modport slave (
    input  alu_valid, alu_rd, alu_data,
    input  ld_issue_valid, ld_issue_rd,
    input  ld_resp_valid, ld_resp_data,
    output alu_ready, ld_issue_ready,
    output wen, wadd, wdata, busy, lq_count, err
  );
endinterface

// File: rtl/regfile_writeback.sv
// Single writer of the integer register file: merges ALU results and in-order load
// responses, with a load-destination FIFO and busy scoreboard for WAW ordering.
// Define REGWB_OUTREG_EN to register wen/wadd/wdata (one cycle after acceptance).
module regfile_writeback #(
  parameter int W        = 31,
  parameter int LQ_DEPTH = 4,
  parameter int LQ_AW    = 2
) (
  input  logic              clk,
  input  logic              rst,
  regfile_writeback_if.slave bus
);

  logic [4:0]       lq_mem_q [LQ_DEPTH];
  logic [LQ_AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [LQ_AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [LQ_AW:0]   cnt_q, cnt_d;
  logic [31:0]      busy_q, busy_d;
  logic             err_q, err_d;

  logic             lq_full, lq_empty;
  logic             issue_ready, alu_ready;
  logic             issue_fire, resp_pop, alu_fire;
  logic [4:0]       head_rd;

  logic             wr_en_d;
  logic [4:0]       wr_addr_d;
  logic [W:0]       wr_data_d;

  assign lq_full  = (cnt_q == (LQ_AW+1)'(LQ_DEPTH));
  assign lq_empty = (cnt_q == '0);
  assign head_rd  = lq_mem_q[rd_ptr_q];

  // Readiness uses the current count, so a full FIFO refuses issue even while popping.
  assign issue_ready = !lq_full && !busy_q[bus.ld_issue_rd];
  assign alu_ready   = !bus.ld_resp_valid && !busy_q[bus.alu_rd];

  assign issue_fire = bus.ld_issue_valid && issue_ready;
  assign resp_pop   = bus.ld_resp_valid && !lq_empty;
  assign alu_fire   = bus.alu_valid && alu_ready;

  always_comb begin
    // NOTE: every variable driven here gets a default first so no latch is inferred.
    wr_ptr_d  = wr_ptr_q;
    rd_ptr_d  = rd_ptr_q;
    busy_d    = busy_q;
    err_d     = err_q;
    wr_en_d   = 1'b0;
    wr_addr_d = '0;
    wr_data_d = '0;

    if (resp_pop) begin
      rd_ptr_d        = rd_ptr_q + LQ_AW'(1);
      busy_d[head_rd] = 1'b0;
      if (head_rd != 5'd0) begin
        wr_en_d   = 1'b1;
        wr_addr_d = head_rd;
        wr_data_d = bus.ld_resp_data;
      end
    end else if (alu_fire && bus.alu_rd != 5'd0) begin
      wr_en_d   = 1'b1;
      wr_addr_d = bus.alu_rd;
      wr_data_d = bus.alu_data;
    end

    if (bus.ld_resp_valid && lq_empty) err_d = 1'b1;

    if (issue_fire) begin
      wr_ptr_d                  = wr_ptr_q + LQ_AW'(1);
      busy_d[bus.ld_issue_rd]   = 1'b1;
    end

    // x0 is never tracked; loads to it still occupy a FIFO slot for ordering.
    busy_d[0] = 1'b0;
    cnt_d     = cnt_q + (LQ_AW+1)'(issue_fire) - (LQ_AW+1)'(resp_pop);
  end

  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only.
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      busy_q   <= '0;
      err_q    <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      err_q    <= err_d;
    end
  end

  // NOTE: FIFO storage has no reset; the pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (issue_fire) lq_mem_q[wr_ptr_q] <= bus.ld_issue_rd;
  end

`ifdef REGWB_OUTREG_EN
  logic       wen_q;
  logic [4:0] wadd_q;
  logic [W:0] wdata_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      wen_q   <= 1'b0;
      wadd_q  <= '0;
      wdata_q <= '0;
    end else begin
      wen_q   <= wr_en_d;
      wadd_q  <= wr_addr_d;
      wdata_q <= wr_data_d;
    end
  end

  assign bus.wen   = wen_q;
  assign bus.wadd  = wadd_q;
  assign bus.wdata = wdata_q;
`else
  assign bus.wen   = wr_en_d && !rst;
  assign bus.wadd  = rst ? 5'd0 : wr_addr_d;
  assign bus.wdata = rst ? '0 : wr_data_d;
`endif

  assign bus.alu_ready      = alu_ready;
  assign bus.ld_issue_ready = issue_ready;
  assign bus.busy           = busy_q;
  assign bus.lq_count       = cnt_q;
  assign bus.err            = err_q;

endmodule

// File: tb/tb_regfile_writeback.sv
// Bench for regfile_writeback: queue-based reference model checked every cycle,
// directed scenarios with literal expectations, then randomized traffic.
module tb_regfile_writeback;
  localparam int W        = 31;
  localparam int LQ_DEPTH = 4;
  localparam int LQ_AW    = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  regfile_writeback_if #(.W(W), .LQ_AW(LQ_AW)) wb_if ();

  regfile_writeback #(.W(W), .LQ_DEPTH(LQ_DEPTH), .LQ_AW(LQ_AW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (wb_if)
  );

  typedef struct packed {
    logic [4:0] rd;
    logic [W:0] data;
  } wr_t;

  int   n_checks = 0;
  int   n_pass   = 0;
  logic [4:0] m_q[$];
  logic m_err;
  logic model_ok = 1'b0;
  logic m_pend_en;
  wr_t  m_pend;
  wr_t  dut_log[$];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
  endtask

  // Reference model: outstanding loads are a queue of destinations; busy is
  // membership in that queue; writes follow from the priority rules.
  always @(negedge clk) begin
    logic [31:0] eb;
    logic        ir, ar, cen, exp_en;
    wr_t         cw, exp_w;
    if (rst) begin
      m_q.delete();
      m_err     = 1'b0;
      m_pend_en = 1'b0;
      m_pend    = '0;
      model_ok  = 1'b1;
    end else if (model_ok) begin
      eb = '0;
      foreach (m_q[i]) if (m_q[i] != 5'd0) eb[m_q[i]] = 1'b1;
      ir = (m_q.size() < LQ_DEPTH) && !eb[wb_if.ld_issue_rd];
      ar = !wb_if.ld_resp_valid && !eb[wb_if.alu_rd];
      cen = 1'b0;
      cw  = '0;
      if (wb_if.ld_resp_valid && m_q.size() > 0) begin
        cw.rd   = m_q[0];
        cw.data = wb_if.ld_resp_data;
        cen     = (m_q[0] != 5'd0);
      end else if (wb_if.alu_valid && ar) begin
        cw.rd   = wb_if.alu_rd;
        cw.data = wb_if.alu_data;
        cen     = (wb_if.alu_rd != 5'd0);
      end

      check("busy", 64'(wb_if.busy), 64'(eb));
      check("lq_count", 64'(wb_if.lq_count), 64'(m_q.size()));
      check("err", 64'(wb_if.err), 64'(m_err));
      check("ld_issue_ready", 64'(wb_if.ld_issue_ready), 64'(ir));
      check("alu_ready", 64'(wb_if.alu_ready), 64'(ar));

`ifdef REGWB_OUTREG_EN
      exp_en    = m_pend_en;
      exp_w     = m_pend;
      m_pend_en = cen;
      m_pend    = cw;
`else
      exp_en = cen;
      exp_w  = cw;
`endif
      check("wen", 64'(wb_if.wen), 64'(exp_en));
      if (exp_en) begin
        check("wadd", 64'(wb_if.wadd), 64'(exp_w.rd));
        check("wdata", 64'(wb_if.wdata), 64'(exp_w.data));
      end
      if (wb_if.wen === 1'b1) dut_log.push_back({wb_if.wadd, wb_if.wdata});

      if (wb_if.ld_resp_valid) begin
        if (m_q.size() > 0) void'(m_q.pop_front());
        else m_err = 1'b1;
      end
      if (wb_if.ld_issue_valid && ir) m_q.push_back(wb_if.ld_issue_rd);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    wb_if.alu_valid      = 1'b0;
    wb_if.alu_rd         = '0;
    wb_if.alu_data       = '0;
    wb_if.ld_issue_valid = 1'b0;
    wb_if.ld_issue_rd    = '0;
    wb_if.ld_resp_valid  = 1'b0;
    wb_if.ld_resp_data   = '0;
  endtask

  task automatic log_at(input string name, input int idx, input logic [4:0] rd, input logic [W:0] data);
    wr_t got;
    wr_t want;
    got  = (idx < dut_log.size()) ? dut_log[idx] : '1;
    want = {rd, data};
    check(name, 64'(got), 64'(want));
  endtask

  initial begin
    idle();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
    check("reset_busy", 64'(wb_if.busy), 64'h0);
    check("reset_count", 64'(wb_if.lq_count), 64'h0);
    check("reset_err", 64'(wb_if.err), 64'h0);
    check("reset_wen", 64'(wb_if.wen), 64'h0);

    // Simple ALU write
    dut_log.delete();
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd5;
    wb_if.alu_data  = 32'hDEADBEEF;
`ifdef REGWB_OUTREG_EN
    step();
    idle();
    #1;
`else
    #1;
`endif
    check("alu_wen", 64'(wb_if.wen), 64'h1);
    check("alu_wadd", 64'(wb_if.wadd), 64'h5);
    check("alu_wdata", 64'(wb_if.wdata), 64'hDEADBEEF);
    step();
    idle();
    step();
    step();
    check("alu_log_len", 64'(dut_log.size()), 64'h1);
    log_at("alu_log0", 0, 5'd5, 32'hDEADBEEF);

    // Fill the load FIFO, then drain it
    dut_log.delete();
    for (int r = 1; r <= 4; r++) begin
      wb_if.ld_issue_valid = 1'b1;
      wb_if.ld_issue_rd    = 5'(r);
      step();
    end
    wb_if.ld_issue_rd = 5'd6;
    #1;
    check("full_issue_ready", 64'(wb_if.ld_issue_ready), 64'h0);
    check("full_count", 64'(wb_if.lq_count), 64'h4);
    check("full_busy", 64'(wb_if.busy), 64'h1E);
    step();
    wb_if.ld_issue_valid = 1'b0;
    for (int k = 0; k < 4; k++) begin
      wb_if.ld_resp_valid = 1'b1;
      wb_if.ld_resp_data  = 32'h11 * (k + 1);
      step();
    end
    idle();
    step();
    step();
    check("drain_log_len", 64'(dut_log.size()), 64'h4);
    log_at("drain_log0", 0, 5'd1, 32'h11);
    log_at("drain_log1", 1, 5'd2, 32'h22);
    log_at("drain_log2", 2, 5'd3, 32'h33);
    log_at("drain_log3", 3, 5'd4, 32'h44);
    check("drain_busy", 64'(wb_if.busy), 64'h0);
    check("drain_count", 64'(wb_if.lq_count), 64'h0);

    // Load response collides with an ALU offer
    dut_log.delete();
    wb_if.ld_issue_valid = 1'b1;
    wb_if.ld_issue_rd    = 5'd10;
    step();
    wb_if.ld_issue_valid = 1'b0;
    wb_if.ld_resp_valid  = 1'b1;
    wb_if.ld_resp_data   = 32'hAA;
    wb_if.alu_valid      = 1'b1;
    wb_if.alu_rd         = 5'd9;
    wb_if.alu_data       = 32'h99;
    #1;
    check("collide_alu_ready", 64'(wb_if.alu_ready), 64'h0);
    step();
    wb_if.ld_resp_valid = 1'b0;
    #1;
    check("collide_alu_ready_next", 64'(wb_if.alu_ready), 64'h1);
    step();
    idle();
    step();
    step();
    check("collide_log_len", 64'(dut_log.size()), 64'h2);
    log_at("collide_log0", 0, 5'd10, 32'hAA);
    log_at("collide_log1", 1, 5'd9, 32'h99);

    // WAW block on rd 7
    dut_log.delete();
    wb_if.ld_issue_valid = 1'b1;
    wb_if.ld_issue_rd    = 5'd7;
    step();
    wb_if.alu_valid = 1'b1;
    wb_if.alu_rd    = 5'd7;
    wb_if.alu_data  = 32'h77;
    for (int c = 0; c < 3; c++) begin
      #1;
      check("waw_alu_blocked", 64'(wb_if.alu_ready), 64'h0);
      check("waw_issue_blocked", 64'(wb_if.ld_issue_ready), 64'h0);
      step();
    end
    wb_if.ld_resp_valid = 1'b1;
    wb_if.ld_resp_data  = 32'h70;
    #1;
    check("waw_same_cycle_issue", 64'(wb_if.ld_issue_ready), 64'h0);
    step();
    wb_if.ld_resp_valid = 1'b0;
    #1;
    check("waw_alu_released", 64'(wb_if.alu_ready), 64'h1);
    check("waw_issue_released", 64'(wb_if.ld_issue_ready), 64'h1);
    step();
    idle();
    step();
    wb_if.ld_resp_valid = 1'b1;
    wb_if.ld_resp_data  = 32'h7F;
    step();
    idle();
    step();
    step();
    check("waw_log_len", 64'(dut_log.size()), 64'h3);
    log_at("waw_log0", 0, 5'd7, 32'h70);
    log_at("waw_log1", 1, 5'd7, 32'h77);
    log_at("waw_log2", 2, 5'd7, 32'h7F);

    // Load to x0, then a response with the FIFO empty
    dut_log.delete();
    wb_if.ld_issue_valid = 1'b1;
    wb_if.ld_issue_rd    = 5'd0;
    step();
    wb_if.ld_issue_valid = 1'b0;
    #1;
    check("x0_count1", 64'(wb_if.lq_count), 64'h1);
    check("x0_busy", 64'(wb_if.busy), 64'h0);
    wb_if.ld_resp_valid = 1'b1;
    wb_if.ld_resp_data  = 32'h55;
    step();
    wb_if.ld_resp_valid = 1'b0;
    #1;
    check("x0_count0", 64'(wb_if.lq_count), 64'h0);
    step();
    step();
    check("x0_no_write", 64'(dut_log.size()), 64'h0);
    wb_if.ld_resp_valid = 1'b1;
    wb_if.ld_resp_data  = 32'h66;
    step();
    wb_if.ld_resp_valid = 1'b0;
    #1;
    check("empty_resp_err", 64'(wb_if.err), 64'h1);
    step();
    step();
    step();
    check("err_sticky", 64'(wb_if.err), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("err_cleared", 64'(wb_if.err), 64'h0);

    // Ten overlapped issue/response pairs wrap the pointers
    dut_log.delete();
    for (int k = 0; k <= 10; k++) begin
      wb_if.ld_issue_valid = (k < 10);
      wb_if.ld_issue_rd    = 5'(11 + k);
      wb_if.ld_resp_valid  = (k > 0);
      wb_if.ld_resp_data   = 32'h100 + 32'(k - 1);
      step();
    end
    idle();
    step();
    step();
    check("wrap_log_len", 64'(dut_log.size()), 64'd10);
    for (int k = 0; k < 10; k++) log_at("wrap_order", k, 5'(11 + k), 32'h100 + 32'(k));

    // Reset with three loads outstanding
    for (int k = 0; k < 3; k++) begin
      wb_if.ld_issue_valid = 1'b1;
      wb_if.ld_issue_rd    = 5'(21 + k);
      step();
    end
    idle();
    #1;
    check("midflight_count", 64'(wb_if.lq_count), 64'h3);
    rst = 1'b1;
    step();
    rst = 1'b0;
    #1;
    check("post_reset_count", 64'(wb_if.lq_count), 64'h0);
    check("post_reset_busy", 64'(wb_if.busy), 64'h0);
    wb_if.ld_resp_valid = 1'b1;
    wb_if.ld_resp_data  = 32'h5A;
    step();
    wb_if.ld_resp_valid = 1'b0;
    #1;
    check("stale_resp_err", 64'(wb_if.err), 64'h1);
    rst = 1'b1;
    step();
    rst = 1'b0;

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      wb_if.alu_valid      = 1'($urandom_range(0, 1));
      wb_if.alu_rd         = 5'($urandom_range(0, 7));
      wb_if.alu_data       = $urandom();
      wb_if.ld_issue_valid = ($urandom_range(0, 2) == 0);
      wb_if.ld_issue_rd    = 5'($urandom_range(0, 7));
      wb_if.ld_resp_valid  = (m_q.size() > 0) ? ($urandom_range(0, 2) == 0)
                                              : ($urandom_range(0, 63) == 0);
      wb_if.ld_resp_data   = $urandom();
      rst                  = ((c % 700) == 699);
      step();
    end
    idle();
    rst = 1'b0;
    step();
    step();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
